// File: rtl/id_of_stage_reg_if.sv
// ID->OF pipeline register interface.
// Groups the decoder-side handshake (id_*), the hazard and flush controls,
// and the operand-fetch-side handshake (of_*) into one bundle.
// The slave modport is the stage register's view. The master modport is the
// view of the surrounding pipeline (decoder, control logic and OF).
interface id_of_stage_reg_if #(
    parameter int INSTR_W   = 64,
    parameter int REGMASK_W = 16
);
    logic                 id_valid;
    logic                 id_ready;
    logic [INSTR_W-1:0]   id_instr;
    logic [REGMASK_W-1:0] id_req;
    logic [REGMASK_W-1:0] id_prov;
    logic                 nop_id;
    logic                 flush;
    logic                 of_valid;
    logic                 of_ready;
    logic [INSTR_W-1:0]   of_instr;
    logic [REGMASK_W-1:0] of_req;
    logic [REGMASK_W-1:0] of_prov;

    modport slave (
        input  id_valid, id_instr, id_req, id_prov, nop_id, flush, of_ready,
        output id_ready, of_valid, of_instr, of_req, of_prov
    );

    modport master (
        output id_valid, id_instr, id_req, id_prov, nop_id, flush, of_ready,
        input  id_ready, of_valid, of_instr, of_req, of_prov
    );
endinterface

// File: rtl/id_of_stage_reg.sv
// ID->OF pipeline register with a valid/ready handshake and a 1-entry skid buffer.
//
// The block holds an output entry and one skid entry. A hazarded instruction
// (nop_id=1) is not accepted, so the decoder keeps it. When OF drains the
// output entry, OF sees a bubble with zeroed masks.
//
// id_ready depends only on reset, flush, nop_id and the registered state.
// There is no combinational path from of_ready to id_ready.
//
// Optional feature: define STALL_STATS_EN to add the stall_cnt port. This is a
// saturating count of the cycles in which a valid instruction is held by a
// hazard.
module id_of_stage_reg #(
    parameter int INSTR_W     = 64,
    parameter int REGMASK_W   = 16
`ifdef STALL_STATS_EN
    ,
    parameter int STALL_CNT_W = 32
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    id_of_stage_reg_if.slave       bus
`ifdef STALL_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    // Occupancy states
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_SKID  = 2'd2;

    logic [1:0]           r_state;
    logic [INSTR_W-1:0]   r_out_instr;
    logic [REGMASK_W-1:0] r_out_req;
    logic [REGMASK_W-1:0] r_out_prov;
    logic [INSTR_W-1:0]   r_skid_instr;
    logic [REGMASK_W-1:0] r_skid_req;
    logic [REGMASK_W-1:0] r_skid_prov;

    logic       w_id_ready;
    logic       w_of_valid;
    logic       w_acc;
    logic       w_deq;
    logic [1:0] w_state_nxt;
    logic       w_out_ld_id;
    logic       w_out_ld_skid;
    logic       w_out_clr;
    logic       w_skid_ld;
    logic       w_skid_clr;

    assign w_of_valid = (r_state != ST_EMPTY);
    assign w_acc      = bus.id_valid & w_id_ready;
    assign w_deq      = w_of_valid & bus.of_ready;

    // Upstream ready: blocked by reset, flush, hazard or a full skid buffer
    always_comb begin
        if (reset && !bus.flush && !bus.nop_id && (r_state != ST_SKID)) begin
            w_id_ready = 1'b1;
        end else begin
            w_id_ready = 1'b0;
        end
    end

    // Next-state and datapath load selection; flush overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_out_ld_id   = 1'b0;
        w_out_ld_skid = 1'b0;
        w_out_clr     = 1'b0;
        w_skid_ld     = 1'b0;
        w_skid_clr    = 1'b0;
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_out_clr   = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt = ST_FULL;
                        w_out_ld_id = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_acc && w_deq) begin
                        w_state_nxt = ST_FULL;
                        w_out_ld_id = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = ST_SKID;
                        w_skid_ld   = 1'b1;
                    end else if (w_deq) begin
                        w_state_nxt = ST_EMPTY;
                        w_out_clr   = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (w_deq) begin
                        w_state_nxt   = ST_FULL;
                        w_out_ld_skid = 1'b1;
                        w_skid_clr    = 1'b1;
                    end else begin
                        w_state_nxt = ST_SKID;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean empty pipe
                    w_state_nxt = ST_EMPTY;
                    w_out_clr   = 1'b1;
                    w_skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output entry: loaded from ID or skid, cleared whenever it becomes invalid
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_instr <= {INSTR_W{1'b0}};
            r_out_req   <= {REGMASK_W{1'b0}};
            r_out_prov  <= {REGMASK_W{1'b0}};
        end else if (w_out_clr) begin
            r_out_instr <= {INSTR_W{1'b0}};
            r_out_req   <= {REGMASK_W{1'b0}};
            r_out_prov  <= {REGMASK_W{1'b0}};
        end else if (w_out_ld_skid) begin
            r_out_instr <= r_skid_instr;
            r_out_req   <= r_skid_req;
            r_out_prov  <= r_skid_prov;
        end else if (w_out_ld_id) begin
            r_out_instr <= bus.id_instr;
            r_out_req   <= bus.id_req;
            r_out_prov  <= bus.id_prov;
        end
    end

    // Skid entry: captures an accepted instruction while OF is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_instr <= {INSTR_W{1'b0}};
            r_skid_req   <= {REGMASK_W{1'b0}};
            r_skid_prov  <= {REGMASK_W{1'b0}};
        end else if (w_skid_clr) begin
            r_skid_instr <= {INSTR_W{1'b0}};
            r_skid_req   <= {REGMASK_W{1'b0}};
            r_skid_prov  <= {REGMASK_W{1'b0}};
        end else if (w_skid_ld) begin
            r_skid_instr <= bus.id_instr;
            r_skid_req   <= bus.id_req;
            r_skid_prov  <= bus.id_prov;
        end
    end

    assign bus.id_ready = w_id_ready;
    assign bus.of_valid = w_of_valid;
    assign bus.of_instr = r_out_instr;
    // Masks are also gated by validity, so a bubble can never carry stale masks
    assign bus.of_req   = r_out_req  & {REGMASK_W{w_of_valid}};
    assign bus.of_prov  = r_out_prov & {REGMASK_W{w_of_valid}};

`ifdef STALL_STATS_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic                   w_stall_evt;

    assign w_stall_evt = bus.id_valid & bus.nop_id & ~bus.flush;

    // Saturating hazard-stall cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= {STALL_CNT_W{1'b0}};
        end else if (w_stall_evt && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
